// File: rtl/serial_comm_pkg.sv
// Shared definitions for the serial frame detector / word assembler pair.
// Holds the framing constants and the assembler FSM state type.
package serial_comm_pkg;

  localparam logic [5:0] FRAME_START_SEQ = 6'b011010;
  localparam int         FRAME_WORD_W    = 32;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } asm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty reads as zero so a stale entry never leaks out after reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Assembles MSB-first payload bits from the frame detector into words and
// queues them for the parallel side; flags truncated frames and drops.
module serial_word_assembler
  import serial_comm_pkg::*;
#(
  parameter int WORD_W     = FRAME_WORD_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_data,
  input  logic              ser_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_err,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int              CW       = $clog2(WORD_W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WORD_W - 1);

  asm_state_t        state;
  logic [CW-1:0]     cnt;
  // Only WORD_W-1 bits are stored: the final bit goes straight into the word.
  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] word_in;
  logic              word_done;
  logic              word_pop;
  logic              word_drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign word_in    = {shreg, ser_data};
  assign word_done  = (state == S_SHIFT) && ser_valid && (cnt == CNT_LAST);
  assign word_valid = !fifo_empty;
  assign word_pop   = word_valid && word_ready;
  assign word_drop  = word_done && fifo_full && !word_pop;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (ser_valid) shreg <= {shreg[WORD_W-3:0], ser_data};

      case (state)
        S_IDLE: begin
          if (ser_valid) begin
            cnt   <= CW'(1);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!ser_valid) begin
            frame_err <= 1'b1;
            cnt       <= '0;
            state     <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A new drop outranks a simultaneous clear.
      if (word_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .pop   (word_pop),
    .wdata (word_in),
    .rdata (word_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
